// File: rtl/bram_s1_s4_fifo_ctrl_if.sv
// Push/pop handshake between the serial producer, the nibble consumer and the FIFO controller.
// The consumer side sees RAM read data directly as rd_data, qualified by rd_valid.
interface bram_s1_s4_fifo_ctrl_if;
    logic       wr_en;
    logic       wr_bit;
    logic       wr_ready;
    logic       rd_en;
    logic       rd_avail;
    logic [3:0] rd_data;
    logic       rd_valid;

    modport master (
        output wr_en, wr_bit, rd_en,
        input  wr_ready, rd_avail, rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_bit, rd_en,
        output wr_ready, rd_avail, rd_data, rd_valid
    );
endinterface

// File: rtl/bram_s1_s4_fifo_ctrl.sv
// FIFO controller for a 4096x1 (write) / 1024x4 (read) dual-port block RAM.
// Define BRAM_FIFO_CLR_EN to zero the whole RAM through port B after reset before accepting traffic.
module bram_s1_s4_fifo_ctrl #(
    parameter int AFULL_LVL  = 4032,
    parameter int AEMPTY_LVL = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    bram_s1_s4_fifo_ctrl_if.slave        bus,
    output logic [12:0]                  count,
    output logic                         afull,
    output logic                         aempty,
    output logic                         ovf,
    output logic                         udf,
    output logic                         busy,
    output logic [11:0]                  ram_addra,
    output logic                         ram_dia,
    output logic                         ram_ena,
    output logic                         ram_wea,
    output logic [9:0]                   ram_addrb,
    output logic [3:0]                   ram_dib,
    output logic                         ram_enb,
    output logic                         ram_web,
    input  logic [3:0]                   ram_dob
);

    logic [11:0] wptr_r;
    logic [9:0]  rptr_r;
    logic [12:0] count_r;
    logic        ovf_r;
    logic        udf_r;
    logic        rd_valid_r;
    logic        run_s;
    logic        clear_s;
    logic        wr_ready_s;
    logic        rd_avail_s;
    logic        push_s;
    logic        pop_s;

`ifdef BRAM_FIFO_CLR_EN
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: the sweep reuses rptr as its address and ends after nibble 1023
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CLEAR: begin
                if (rptr_r == 10'd1023) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            RUN:     state_nxt_s = RUN;
            default: state_nxt_s = CLEAR;
        endcase
    end

    assign clear_s = (state_r == CLEAR);
    assign run_s   = (state_r == RUN);
`else
    assign clear_s = 1'b0;
    assign run_s   = 1'b1;
`endif

    // Readiness looks only at the current occupancy, so a same-cycle pop never makes room for a push
    assign wr_ready_s = run_s & (count_r < 13'd4096);
    assign rd_avail_s = run_s & (count_r >= 13'd4);
    assign push_s     = bus.wr_en & wr_ready_s & ~flush;
    assign pop_s      = bus.rd_en & rd_avail_s & ~flush;

    // Pointers, occupancy, sticky error flags and read-valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r     <= 12'd0;
            rptr_r     <= 10'd0;
            count_r    <= 13'd0;
            ovf_r      <= 1'b0;
            udf_r      <= 1'b0;
            rd_valid_r <= 1'b0;
        end else if (clear_s) begin
            rptr_r     <= rptr_r + 10'd1;
            rd_valid_r <= 1'b0;
        end else if (flush) begin
            wptr_r     <= 12'd0;
            rptr_r     <= 10'd0;
            count_r    <= 13'd0;
            ovf_r      <= 1'b0;
            udf_r      <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + 12'd1;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 10'd1;
            end
            count_r <= count_r + {12'd0, push_s} - {10'd0, pop_s, 2'b00};
            if (bus.wr_en && !wr_ready_s) begin
                ovf_r <= 1'b1;
            end
            if (bus.rd_en && !rd_avail_s) begin
                udf_r <= 1'b1;
            end
            rd_valid_r <= pop_s;
        end
    end

    assign bus.wr_ready = wr_ready_s;
    assign bus.rd_avail = rd_avail_s;
    assign bus.rd_data  = ram_dob;
    assign bus.rd_valid = rd_valid_r;

    assign count  = count_r;
    assign afull  = (count_r >= 13'(AFULL_LVL));
    assign aempty = (count_r <= 13'(AEMPTY_LVL));
    assign ovf    = ovf_r;
    assign udf    = udf_r;
    assign busy   = clear_s;

    // Port B doubles as the zeroing path during the clear sweep
    assign ram_addra = wptr_r;
    assign ram_dia   = bus.wr_bit;
    assign ram_ena   = push_s;
    assign ram_wea   = push_s;
    assign ram_addrb = rptr_r;
    assign ram_dib   = 4'd0;
    assign ram_enb   = clear_s | pop_s;
    assign ram_web   = clear_s;

endmodule
